// File: rtl/median3x3_sched.sv
// Exact 3x3 median scheduled onto one shared, externally instantiated 3-input sorter.
// Column sort, then row sort of mins/meds/maxes, then one final sort: seven sorter passes.
module median3x3_sched #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                  clk_100M,
    input  logic                  rst_p,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [9*DATA_W-1:0]   in_win,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_med,
    output logic [DATA_W-1:0]     sort_a,
    output logic [DATA_W-1:0]     sort_b,
    output logic [DATA_W-1:0]     sort_c,
    input  logic [DATA_W-1:0]     sort_med,
    input  logic [DATA_W-1:0]     sort_max,
    input  logic [DATA_W-1:0]     sort_min,
    output logic                  busy,
    output logic [CNT_W-1:0]      med_count
);

    typedef enum logic [3:0] {
        IDLE, C0, C1, C2, W2, R0, R1, R2, W3, FN, WF, DONE
    } state_t;

    state_t              r_state;
    logic [9*DATA_W-1:0] r_win;
    logic [DATA_W-1:0]   r_cmin [3];
    logic [DATA_W-1:0]   r_cmed [3];
    logic [DATA_W-1:0]   r_cmax [3];
    logic [DATA_W-1:0]   r_lo;
    logic [DATA_W-1:0]   r_mid;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_out_med;
    logic                r_out_valid;
    logic                r_in_ready;
    logic [CNT_W-1:0]    r_med_count;

    logic [DATA_W-1:0]   w_px [9];
    logic [DATA_W-1:0]   w_sort_a;
    logic [DATA_W-1:0]   w_sort_b;
    logic [DATA_W-1:0]   w_sort_c;

    for (genvar g = 0; g < 9; g++) begin : g_px
        assign w_px[g] = r_win[DATA_W*g +: DATA_W];
    end

    // Sorter results land one cycle after the drive, so each capture sits one state later.
    always_comb begin
        w_sort_a = '0;
        w_sort_b = '0;
        w_sort_c = '0;
        case (r_state)
            C0: begin
                w_sort_a = w_px[0];
                w_sort_b = w_px[3];
                w_sort_c = w_px[6];
            end
            C1: begin
                w_sort_a = w_px[1];
                w_sort_b = w_px[4];
                w_sort_c = w_px[7];
            end
            C2: begin
                w_sort_a = w_px[2];
                w_sort_b = w_px[5];
                w_sort_c = w_px[8];
            end
            R0: begin
                w_sort_a = r_cmin[0];
                w_sort_b = r_cmin[1];
                w_sort_c = r_cmin[2];
            end
            R1: begin
                w_sort_a = r_cmed[0];
                w_sort_b = r_cmed[1];
                w_sort_c = r_cmed[2];
            end
            R2: begin
                w_sort_a = r_cmax[0];
                w_sort_b = r_cmax[1];
                w_sort_c = r_cmax[2];
            end
            FN: begin
                w_sort_a = r_lo;
                w_sort_b = r_mid;
                w_sort_c = r_hi;
            end
            default: ;
        endcase
    end

    // r_in_ready tracks "next state is IDLE" so it stays low while reset is held.
    always_ff @(posedge clk_100M) begin
        if (rst_p) begin
            r_state     <= IDLE;
            r_win       <= '0;
            r_cmin      <= '{default: '0};
            r_cmed      <= '{default: '0};
            r_cmax      <= '{default: '0};
            r_lo        <= '0;
            r_mid       <= '0;
            r_hi        <= '0;
            r_out_med   <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_med_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_win      <= in_win;
                        r_in_ready <= 1'b0;
                        r_state    <= C0;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                C0: r_state <= C1;
                C1: begin
                    r_cmin[0] <= sort_min;
                    r_cmed[0] <= sort_med;
                    r_cmax[0] <= sort_max;
                    r_state   <= C2;
                end
                C2: begin
                    r_cmin[1] <= sort_min;
                    r_cmed[1] <= sort_med;
                    r_cmax[1] <= sort_max;
                    r_state   <= W2;
                end
                W2: begin
                    r_cmin[2] <= sort_min;
                    r_cmed[2] <= sort_med;
                    r_cmax[2] <= sort_max;
                    r_state   <= R0;
                end
                R0: r_state <= R1;
                R1: begin
                    r_lo    <= sort_max;
                    r_state <= R2;
                end
                R2: begin
                    r_mid   <= sort_med;
                    r_state <= W3;
                end
                W3: begin
                    r_hi    <= sort_min;
                    r_state <= FN;
                end
                FN: r_state <= WF;
                WF: begin
                    r_out_med   <= sort_med;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_med_count <= r_med_count + 1'b1;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_in_ready <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign out_med   = r_out_med;
    assign med_count = r_med_count;
    assign sort_a    = w_sort_a;
    assign sort_b    = w_sort_b;
    assign sort_c    = w_sort_c;

endmodule

// File: tb/tb_median3x3_sched.sv
// Bench for median3x3_sched: behavioural one-cycle sorter plus a sort-all-nine median reference.
module tb_median3x3_sched;

    localparam int DW = 8;
    localparam int CW = 4;

    logic            clk_100M = 1'b0;
    logic            rst_p;
    logic            in_valid;
    logic            in_ready;
    logic [9*DW-1:0] in_win;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_med;
    logic [DW-1:0]   sort_a, sort_b, sort_c;
    logic [DW-1:0]   sort_med, sort_max, sort_min;
    logic            busy;
    logic [CW-1:0]   med_count;

    int checks = 0;
    int errors = 0;
    int cnt_model = 0;

    median3x3_sched #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk_100M (clk_100M),
        .rst_p    (rst_p),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_win   (in_win),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_med  (out_med),
        .sort_a   (sort_a),
        .sort_b   (sort_b),
        .sort_c   (sort_c),
        .sort_med (sort_med),
        .sort_max (sort_max),
        .sort_min (sort_min),
        .busy     (busy),
        .med_count(med_count)
    );

    always #5 clk_100M = ~clk_100M;

    function automatic int mx3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    function automatic int mn3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        return m;
    endfunction

    // Sorter stand-in: registered outputs, one clock of latency.
    always @(posedge clk_100M) begin
        sort_max <= DW'(mx3(sort_a, sort_b, sort_c));
        sort_min <= DW'(mn3(sort_a, sort_b, sort_c));
        sort_med <= DW'(int'(sort_a) + int'(sort_b) + int'(sort_c)
                        - mx3(sort_a, sort_b, sort_c) - mn3(sort_a, sort_b, sort_c));
    end

    function automatic logic [DW-1:0] ref_median(input logic [9*DW-1:0] w);
        int v[9];
        int t;
        for (int i = 0; i < 9; i++) v[i] = int'(w[DW*i +: DW]);
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (v[j] > v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
        return DW'(v[4]);
    endfunction

    function automatic logic [9*DW-1:0] pk(input int a0, input int a1, input int a2,
                                           input int a3, input int a4, input int a5,
                                           input int a6, input int a7, input int a8);
        logic [9*DW-1:0] w;
        w = {DW'(a8), DW'(a7), DW'(a6), DW'(a5), DW'(a4), DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
        return w;
    endfunction

    function automatic logic [9*DW-1:0] rand_win(input int maxv);
        logic [9*DW-1:0] w;
        for (int i = 0; i < 9; i++) w[DW*i +: DW] = DW'($urandom_range(0, maxv));
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_100M);
        #1;
    endtask

    // Offers a window, checks latency/result, and completes the handshake if out_ready is high.
    task automatic run_window(input logic [9*DW-1:0] w, input bit drv_chk, input string tag);
        logic [DW-1:0] exp_med;
        logic [DW-1:0] sa[3], sb[3], sc[3];
        int n;
        exp_med = ref_median(w);
        in_win   = w;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick;
            n++;
        end
        chk($sformatf("%s_accept_wait", tag), {31'b0, in_ready}, 32'd1);
        tick;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 30) begin
            if (n == 0 || n == 4 || n == 8) begin
                sa[n/4] = sort_a;
                sb[n/4] = sort_b;
                sc[n/4] = sort_c;
            end
            tick;
            n++;
        end
        chk($sformatf("%s_latency", tag), n, 32'd10);
        chk($sformatf("%s_med", tag), {24'b0, out_med}, {24'b0, exp_med});
        if (drv_chk) begin
            chk("drv_C0", {8'b0, sa[0], sb[0], sc[0]}, {8'b0, 8'd1, 8'd4, 8'd7});
            chk("drv_R0", {8'b0, sa[1], sb[1], sc[1]}, {8'b0, 8'd1, 8'd2, 8'd3});
            chk("drv_FN", {8'b0, sa[2], sb[2], sc[2]}, {8'b0, 8'd3, 8'd5, 8'd7});
        end
        if (out_ready) begin
            tick;
            cnt_model = (cnt_model + 1) % (1 << CW);
            chk($sformatf("%s_count", tag), {28'b0, med_count}, cnt_model);
            chk($sformatf("%s_valid_drop", tag), {31'b0, out_valid}, 32'd0);
            chk($sformatf("%s_in_ready", tag), {31'b0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        logic [9*DW-1:0] wa, wb;
        logic [DW-1:0]   ea;
        int              seen;

        rst_p     = 1'b1;
        in_valid  = 1'b1;
        in_win    = pk(1, 2, 3, 4, 5, 6, 7, 8, 9);
        out_ready = 1'b1;

        tick;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_count", {28'b0, med_count}, 32'd0);
        chk("rst_sort", {8'b0, sort_a, sort_b, sort_c}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        tick;
        chk("rst_in_ready2", {31'b0, in_ready}, 32'd0);
        rst_p = 1'b0;
        tick;
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("post_rst_busy", {31'b0, busy}, 32'd0);

        run_window(pk(1, 2, 3, 4, 5, 6, 7, 8, 9), 1'b1, "seq");
        run_window(pk(9, 9, 9, 0, 0, 0, 5, 5, 5), 1'b0, "rows");
        run_window(pk(7, 7, 7, 7, 7, 7, 7, 7, 7), 1'b0, "all7");
        run_window(pk(9, 8, 7, 6, 5, 4, 3, 2, 1), 1'b0, "desc");
        run_window(pk(255, 0, 255, 0, 255, 0, 255, 0, 255), 1'b0, "alt");
        for (int k = 0; k < 8; k++)
            run_window(rand_win((k % 2 == 0) ? 3 : 255), 1'b0, $sformatf("rnd%0d", k));

        // Backpressure: second window offered while first median is held.
        wa = rand_win(255);
        wb = rand_win(255);
        ea = ref_median(wa);
        out_ready = 1'b0;
        run_window(wa, 1'b0, "bpA");
        in_win   = wb;
        in_valid = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick;
            if (out_med !== ea || out_valid !== 1'b1 || in_ready !== 1'b0) seen++;
        end
        chk("bp_hold", seen, 32'd0);
        chk("bp_count_held", {28'b0, med_count}, cnt_model);
        out_ready = 1'b1;
        tick;
        cnt_model = (cnt_model + 1) % (1 << CW);
        chk("bp_release_count", {28'b0, med_count}, cnt_model);
        run_window(wb, 1'b0, "bpB");

        // Reset while in R1.
        in_win   = pk(1, 2, 3, 4, 5, 6, 7, 8, 9);
        in_valid = 1'b1;
        seen = 0;
        while (!in_ready && seen < 50) begin
            tick;
            seen++;
        end
        tick;
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick;
        chk("mid_busy", {31'b0, busy}, 32'd1);
        rst_p = 1'b1;
        tick;
        rst_p = 1'b0;
        cnt_model = 0;
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_count", {28'b0, med_count}, 32'd0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid !== 1'b0) seen++;
            tick;
        end
        chk("mid_rst_no_valid", seen, 32'd0);
        run_window(pk(1, 2, 3, 4, 5, 6, 7, 8, 9), 1'b0, "after_rst");

        for (int k = 0; k < 15; k++)
            run_window(rand_win((k % 3 == 0) ? 1 : 255), 1'b0, $sformatf("wrap%0d", k));
        chk("wrap_zero", {28'b0, med_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
